mem_stage: RTL

- MEM pipeline stage, fed directly by the EX/MEM pipeline register.
- Executes loads and stores through the CPU's byte-wide RAM port, one byte per cycle.
- Holds the pipeline via a stall request while it is busy.
- Forwards the writeback destination and the result (load data or ALU data) to the MEM/WB register.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_load_ext.sv | 22 ++
 rtl/mem_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared load/store encodings, MEM-stage state encoding and the per-op byte-count helper.
package mem_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LB      = 3'd1;
  localparam logic [2:0] LH      = 3'd2;
  localparam logic [2:0] LW      = 3'd3;
  localparam logic [2:0] LBU     = 3'd4;
  localparam logic [2:0] LHU     = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] SB      = 2'd1;
  localparam logic [1:0] SH      = 2'd2;
  localparam logic [1:0] SW      = 2'd3;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  // A store takes precedence over a simultaneous load; 0 means no memory access.
  function automatic logic [2:0] mem_nbytes(input logic [2:0] rd, input logic [1:0] wr);
    logic [2:0] n;
    n = 3'd0;
    case (wr)
      SB:      n = 3'd1;
      SH:      n = 3'd2;
      SW:      n = 3'd4;
      default: begin
        case (rd)
          LB, LBU: n = 3'd1;
          LH, LHU: n = 3'd2;
          LW:      n = 3'd4;
          default: n = 3'd0;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, byte-wide RAM port, stall request and MEM/WB outputs of the MEM stage.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  logic [2:0]        mem_read;
  logic [1:0]        mem_write;
  logic [4:0]        mem_wd;
  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din_i;

  logic              stall_req_o;
  logic [4:0]        wb_wd;
  logic              wb_wreg;
  logic [31:0]       wb_wdata;

  modport master (
    input  mem_read, mem_write, mem_wd, mem_wreg, mem_waddr, mem_wdata, ram_din_i,
    output ram_addr_o, ram_dout_o, ram_wr_o, stall_req_o, wb_wd, wb_wreg, wb_wdata
  );

  modport slave (
    output mem_read, mem_write, mem_wd, mem_wreg, mem_waddr, mem_wdata, ram_din_i,
    input  ram_addr_o, ram_dout_o, ram_wr_o, stall_req_o, wb_wd, wb_wreg, wb_wdata
  );

endinterface

// File: rtl/mem_load_ext.sv
// Combinational sign/zero extension of the assembled little-endian load buffer by load type.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [2:0]  i_ld_type,
  input  logic [31:0] i_buf,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_ld_type)
      LB:      o_data = {{24{i_buf[7]}}, i_buf[7:0]};
      LH:      o_data = {{16{i_buf[15]}}, i_buf[15:0]};
      LW:      o_data = i_buf;
      LBU:     o_data = {24'h0, i_buf[7:0]};
      LHU:     o_data = {16'h0, i_buf[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over a 1-byte RAM port, stalling n (store) or n+1 (load) cycles.
// Non-memory ops pass through with zero latency. Optional MEM_ALIGN_CHECK_EN adds misalign_o.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master bus
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  generate
    if (LD_LAT != 1) begin : g_lat_chk
      $error("mem_stage: only LD_LAT == 1 is supported");
    end
  endgenerate

  mem_state_t        r_state;
  logic [2:0]        r_cnt;
  logic [31:0]       r_buf;

  logic [2:0]        w_n;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_is_load;
  logic              w_misalign;
  logic              w_last;
  logic [1:0]        w_sel;
  logic [1:0]        w_cap;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_ext;
  logic [ADDR_W-1:0] w_addr;

  assign w_n        = mem_nbytes(bus.mem_read, bus.mem_write);
  assign w_is_store = (bus.mem_write != ST_NONE);
  assign w_is_mem   = (w_n != 3'd0);
  assign w_is_load  = w_is_mem && !w_is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((w_n == 3'd2) && bus.mem_waddr[0]) ||
                      ((w_n == 3'd4) && (bus.mem_waddr[1:0] != 2'b00));
  assign misalign_o = !rst && (r_state == MEM_IDLE) && w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // Loads need one cycle past the last issue to capture the final returning byte.
  assign w_last  = w_is_store ? (r_cnt == (w_n - 3'd1)) : (r_cnt == w_n);
  assign w_sel   = (r_state == MEM_ACCESS) ? r_cnt[1:0] : 2'd0;
  assign w_cap   = r_cnt[1:0] - 2'd1;
  assign w_wbyte = bus.mem_wdata[{w_sel, 3'b000} +: 8];
  assign w_addr  = bus.mem_waddr + ADDR_W'(r_cnt);

  mem_load_ext u_ext (
    .i_ld_type (bus.mem_read),
    .i_buf     (r_buf),
    .o_data    (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MEM_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_is_mem && !w_misalign) begin
            r_cnt   <= 3'd1;
            r_buf   <= '0;
            r_state <= (w_is_store && (w_n == 3'd1)) ? MEM_DONE : MEM_ACCESS;
          end
        end
        MEM_ACCESS: begin
          if (w_is_load) begin
            r_buf[{w_cap, 3'b000} +: 8] <= bus.ram_din_i;
          end
          if (w_last || !w_is_mem) begin
            r_state <= w_is_mem ? MEM_DONE : MEM_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        MEM_DONE: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ram_addr_o  = '0;
    bus.ram_dout_o  = '0;
    bus.ram_wr_o    = 1'b0;
    bus.stall_req_o = 1'b0;
    bus.wb_wd       = '0;
    bus.wb_wreg     = 1'b0;
    bus.wb_wdata    = '0;
    if (!rst) begin
      case (r_state)
        MEM_IDLE: begin
          if (w_misalign) begin
            bus.wb_wd = bus.mem_wd;
          end else if (w_is_mem) begin
            bus.ram_addr_o  = bus.mem_waddr;
            bus.ram_wr_o    = w_is_store;
            bus.ram_dout_o  = w_is_store ? w_wbyte : 8'h00;
            bus.stall_req_o = 1'b1;
          end else begin
            bus.wb_wd    = bus.mem_wd;
            bus.wb_wreg  = bus.mem_wreg;
            bus.wb_wdata = bus.mem_wdata;
          end
        end
        MEM_ACCESS: begin
          bus.stall_req_o = 1'b1;
          if (r_cnt < w_n) begin
            bus.ram_addr_o = w_addr;
            bus.ram_wr_o   = w_is_store;
            bus.ram_dout_o = w_is_store ? w_wbyte : 8'h00;
          end
        end
        MEM_DONE: begin
          bus.wb_wd    = bus.mem_wd;
          bus.wb_wreg  = w_is_load && bus.mem_wreg;
          bus.wb_wdata = w_is_load ? w_ext : 32'h0;
        end
        default: ;
      endcase
    end
  end

endmodule
